// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT frame buffer: read-side FSM states and
// the ring-pointer increment used by both bank pointers.
package fft_buf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    START,
    WAIT
  } rdstate_t;

  // Ring increment for bank counts that need not be powers of two.
  function automatic int unsigned bank_next(input int unsigned bank,
                                            input int unsigned num_banks);
    return (bank == num_banks - 1) ? 0 : bank + 1;
  endfunction

endpackage

// File: rtl/ram1p.sv
// Single-port RAM, one frame deep, with a registered read port (1-cycle latency).
module ram1p #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [N-1:0]         addr,
  input  logic [BIT_WIDTH-1:0] din,
  output logic [BIT_WIDTH-1:0] dout
);

  logic [BIT_WIDTH-1:0] mem [2**N];

  // NOTE: the array has no reset so it can map onto block RAM; its contents
  // are meaningless until written, and only the read register clears.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout <= '0;
    else        dout <= mem[addr];
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ring of NUM_BANKS frame banks between the SPI receiver and the FFT core;
// frames are streamed out oldest-first with load/start/done handshaking.
module fft_frame_buffer
  import fft_buf_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter int NUM_BANKS = 2,
  parameter int DROP_W    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sample_valid,
  input  logic [BIT_WIDTH-1:0]             sample_in,
  input  logic                             continuous,
  input  logic                             arm,
  input  logic                             clr_ovf,
  input  logic                             fft_done,
  output logic                             fft_load,
  output logic [N-1:0]                     add_rd,
  output logic [BIT_WIDTH-1:0]             fft_din,
  output logic                             fft_start,
  output logic [$clog2(NUM_BANKS+1)-1:0]   occupancy,
  output logic                             capturing,
  output logic                             overflow,
  output logic [DROP_W-1:0]                drop_count
);

  localparam int BW    = $clog2(NUM_BANKS);
  localparam int OCC_W = $clog2(NUM_BANKS + 1);

  rdstate_t             state, state_nxt;
  logic [BW-1:0]        wr_bank, rd_bank, rd_bank_d;
  logic [N-1:0]         wr_idx, rd_idx;
  logic [NUM_BANKS-1:0] full;
  logic                 cap_r;
  logic                 wr_en, wr_last, drop, release_frame, load_cyc;
  logic [BIT_WIDTH-1:0] bank_dout [NUM_BANKS];

  assign capturing = cap_r | continuous;
  assign wr_en     = sample_valid && capturing && !full[wr_bank];
  assign wr_last   = wr_en && (&wr_idx);
  assign drop      = sample_valid && capturing && full[wr_bank];

  // Write side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank <= '0;
      wr_idx  <= '0;
      cap_r   <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_idx <= wr_idx + N'(1);
        if (wr_last) wr_bank <= BW'(bank_next(32'(wr_bank), NUM_BANKS));
      end
      if (arm)                          cap_r <= 1'b1;
      else if (wr_last && !continuous)  cap_r <= 1'b0;
    end
  end

  // Write and release always touch different banks, so both full bits may move at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full      <= '0;
      occupancy <= '0;
    end else begin
      if (wr_last)       full[wr_bank] <= 1'b1;
      if (release_frame) full[rd_bank] <= 1'b0;
      case ({wr_last, release_frame})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_ovf) begin
      overflow   <= drop;
      drop_count <= DROP_W'(drop);
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end

  // Read FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default first so every path assigns state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (full[rd_bank]) state_nxt = LOAD;
      LOAD:    if (&rd_idx)       state_nxt = DRAIN;
      DRAIN:                      state_nxt = START;
      START:                      state_nxt = WAIT;
      WAIT:    if (fft_done)      state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_cyc      = (state == LOAD);
    fft_start     = (state == START);
    release_frame = (state == WAIT) && fft_done;
  end

  // Load strobe, index and bank select are delayed to line up with RAM output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx    <= '0;
      rd_bank   <= '0;
      rd_bank_d <= '0;
      fft_load  <= 1'b0;
      add_rd    <= '0;
    end else begin
      if (state == IDLE) rd_idx <= '0;
      else if (load_cyc) rd_idx <= rd_idx + N'(1);
      if (release_frame) rd_bank <= BW'(bank_next(32'(rd_bank), NUM_BANKS));
      rd_bank_d <= rd_bank;
      fft_load  <= load_cyc;
      add_rd    <= rd_idx;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel_rd;
    assign sel_rd = load_cyc && (rd_bank == BW'(b));
    ram1p #(.BIT_WIDTH(BIT_WIDTH), .N(N)) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en && (wr_bank == BW'(b))),
      .addr  (sel_rd ? rd_idx : wr_idx),
      .din   (sample_in),
      .dout  (bank_dout[b])
    );
  end

  assign fft_din = bank_dout[rd_bank_d];

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer (3 banks, 16-sample frames): a frame-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fft_frame_buffer;

  localparam int NB = 3;
  localparam int FS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        continuous = 1'b1;
  logic        arm = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        fft_done = 1'b0;
  logic        fft_load, fft_start, capturing, overflow;
  logic [3:0]  add_rd;
  logic [15:0] fft_din, drop_count;
  logic [1:0]  occupancy;

  fft_frame_buffer #(.BIT_WIDTH(16), .N(4), .NUM_BANKS(NB), .DROP_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .continuous   (continuous),
    .arm          (arm),
    .clr_ovf      (clr_ovf),
    .fft_done     (fft_done),
    .fft_load     (fft_load),
    .add_rd       (add_rd),
    .fft_din      (fft_din),
    .fft_start    (fft_start),
    .occupancy    (occupancy),
    .capturing    (capturing),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int d_checks = 0, d_errs = 0;
  int m_checks = 0, m_errs = 0;

  task automatic chk_d(input string name, input logic [31:0] act, input logic [31:0] exp);
    d_checks++;
    if (act !== exp) begin
      d_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_m(input string name, input logic [31:0] act, input logic [31:0] exp);
    m_checks++;
    if (act !== exp) begin
      m_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: counts of full frames, samples of completed frames in
  // arrival order, and the write-side flags, advanced from the inputs that the
  // next rising edge will sample.
  int          m_occ, m_drops, m_pos;
  bit          m_cap, m_ovf, m_wait, m_exp_start;
  logic [15:0] cur_q[$], exp_q[$];
  int          starts_seen = 0, frames_seen = 0;

  always @(negedge clk) begin
    bit          start_now, cap_eff, acc, drp, rel, done_frame;
    logic [15:0] e;
    start_now = 1'b0;
    if (!reset) begin
      m_occ = 0; m_drops = 0; m_pos = 0;
      m_cap = 1'b1; m_ovf = 1'b0; m_wait = 1'b0; m_exp_start = 1'b0;
      cur_q.delete();
      exp_q.delete();
    end else begin
      chk_m("occupancy", occupancy, m_occ);
      chk_m("capturing", capturing, m_cap | continuous);
      chk_m("overflow", overflow, m_ovf);
      chk_m("drop_count", drop_count, m_drops);
      chk_m("fft_start", fft_start, m_exp_start);
      if (fft_start && m_exp_start) begin
        start_now = 1'b1;
        starts_seen++;
      end
      m_exp_start = 1'b0;
      if (fft_load) begin
        if (exp_q.size() == 0) chk_m("fft_load_unexpected", fft_load, 0);
        else begin
          e = exp_q.pop_front();
          chk_m("add_rd", add_rd, m_pos);
          chk_m("fft_din", fft_din, e);
          m_pos++;
          if (m_pos == FS) begin
            m_pos = 0;
            m_exp_start = 1'b1;
            frames_seen++;
          end
        end
      end else if (m_pos != 0) begin
        chk_m("fft_load_gap", fft_load, 1);
      end

      cap_eff    = m_cap | continuous;
      acc        = sample_valid && cap_eff && (m_occ < NB);
      drp        = sample_valid && cap_eff && (m_occ == NB);
      rel        = fft_done && m_wait;
      done_frame = 1'b0;
      if (acc) begin
        cur_q.push_back(sample_in);
        if (cur_q.size() == FS) begin
          foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
          cur_q.delete();
          done_frame = 1'b1;
        end
      end
      if (rel) m_wait = 1'b0;
      m_occ = m_occ + int'(done_frame) - int'(rel);
      if (arm)                              m_cap = 1'b1;
      else if (done_frame && !continuous)   m_cap = 1'b0;
      if (clr_ovf) begin
        m_ovf   = drp;
        m_drops = int'(drp);
      end else if (drp) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      if (start_now) m_wait = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
    sample_valid = 1'b0;
  endtask

  int served = 0;

  // Answer the next outstanding fft_start with a one-cycle fft_done.
  task automatic serve();
    int t = 0;
    while (starts_seen <= served && t < 200) begin
      tick();
      t++;
    end
    if (starts_seen <= served) chk_d("fft_start_timeout", starts_seen, served + 1);
    else begin
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
    end
    served++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_d({tag, "_fft_load"}, fft_load, 0);
    chk_d({tag, "_add_rd"}, add_rd, 0);
    chk_d({tag, "_fft_din"}, fft_din, 0);
    chk_d({tag, "_fft_start"}, fft_start, 0);
    chk_d({tag, "_occupancy"}, occupancy, 0);
    chk_d({tag, "_capturing"}, capturing, 1);
    chk_d({tag, "_overflow"}, overflow, 0);
    chk_d({tag, "_drop_count"}, drop_count, 0);
  endtask

  initial begin
    int lat;
    #1 reset = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();

    // Single frame: data = index, fixed write-to-load latency.
    for (int i = 0; i < FS; i++) send(16'(i));
    lat = 0;
    while (!fft_load && lat < 10) begin
      tick();
      lat++;
    end
    chk_d("first_load_latency", lat, 2);
    chk_d("first_add_rd", add_rd, 0);
    chk_d("first_fft_din", fft_din, 0);
    chk_d("single_occupancy_before_done", occupancy, 1);
    serve();
    chk_d("single_occupancy_after_done", occupancy, 0);

    // Overflow: 56 samples into a 3-bank ring with no releases.
    for (int i = 0; i < 56; i++) send(16'(16'h0100 + i));
    chk_d("ovf_occupancy", occupancy, 3);
    chk_d("ovf_flag", overflow, 1);
    chk_d("ovf_drop_count", drop_count, 8);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk_d("clr_drop_count", drop_count, 0);
    chk_d("clr_overflow", overflow, 0);
    sample_valid = 1'b1;
    sample_in    = 16'hdead;
    clr_ovf      = 1'b1;
    tick();
    sample_valid = 1'b0;
    clr_ovf      = 1'b0;
    chk_d("clr_with_drop_overflow", overflow, 1);
    chk_d("clr_with_drop_count", drop_count, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    for (int k = 0; k < 3; k++) serve();
    chk_d("ovf_drained_occupancy", occupancy, 0);

    // Wrap-around with a write completion landing on a release cycle.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FS; i++) send(16'(16'h1000 + f * 16 + i));
    for (int i = 0; i < FS - 1; i++) send(16'(16'h1020 + i));
    chk_d("simul_occupancy_before", occupancy, 2);
    lat = 0;
    while (starts_seen <= served && lat < 200) begin
      tick();
      lat++;
    end
    chk_d("simul_start_seen", starts_seen, served + 1);
    sample_valid = 1'b1;
    sample_in    = 16'h102f;
    fft_done     = 1'b1;
    tick();
    sample_valid = 1'b0;
    fft_done     = 1'b0;
    served++;
    chk_d("simul_occupancy_after", occupancy, 2);
    for (int f = 3; f < 7; f++) begin
      for (int i = 0; i < FS; i++) send(16'(16'h1000 + f * 16 + i));
      serve();
    end
    serve();
    serve();
    chk_d("wrap_occupancy", occupancy, 0);
    chk_d("wrap_drop_count", drop_count, 0);
    chk_d("frames_delivered", frames_seen, 11);

    // Single-shot capture.
    continuous = 1'b0;
    for (int i = 0; i < 20; i++) send(16'(16'h0200 + i));
    chk_d("oneshot_capturing", capturing, 0);
    chk_d("oneshot_drop_count", drop_count, 0);
    chk_d("oneshot_occupancy", occupancy, 1);
    serve();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk_d("armed_capturing", capturing, 1);
    for (int i = 0; i < FS; i++) send(16'(16'h0300 + i));
    chk_d("rearmed_capturing", capturing, 0);
    chk_d("rearmed_occupancy", occupancy, 1);
    serve();
    chk_d("oneshot_frames", frames_seen, 13);

    // Reset in the middle of LOAD.
    continuous = 1'b1;
    for (int i = 0; i < FS; i++) send(16'(16'h0400 + i));
    lat = 0;
    while (!(fft_load && add_rd == 4'd7) && lat < 50) begin
      tick();
      lat++;
    end
    chk_d("midload_reached", add_rd, 7);
    reset = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk_d("post_reset_starts", starts_seen, served);
    chk_d("post_reset_occupancy", occupancy, 0);

    // Ring is usable again after the reset.
    for (int i = 0; i < FS; i++) send(16'(16'h0500 + 15 - i));
    served = starts_seen;
    serve();
    chk_d("final_frames", frames_seen, 14);

    $display("Result: errors=%0d of %0d checks", d_errs + m_errs, d_checks + m_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Parametrised multi-bank frame buffer between the SPI sample receiver and the FFT core. Incoming samples are written into a ring of `NUM_BANKS` single-port RAM banks, one frame of `2**N` samples per bank. Completed frames are streamed to the FFT in arrival order, with load, start and done handshaking. Replaces the fixed two-buffer ping-pong logic and adds arbitrary bank count, overflow accounting and single-shot capture mode.

## Interface

**Parameters**
- `BIT_WIDTH`, 16: sample width.
- `N`, 9: log2 of the frame size; `FRAME_SIZE = 2**N`.
- `NUM_BANKS`, 2: bank count; legal range is 2 to 8, not restricted to powers of two.
- `DROP_W`, 16: width of the dropped-sample counter.

**Ports**
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe from SPI (`received_wd`).
- `sample_in`  in  BIT_WIDTH  sample qualified by `sample_valid`.
- `continuous`  in  1  1 = free-running capture; 0 = single-shot capture.
- `arm`  in  1  pulse that re-enables capture in single-shot mode.
- `clr_ovf`  in  1  pulse that clears `overflow` and `drop_count`.
- `fft_done`  in  1  FFT completion pulse.
- `fft_load`  out  1  high while `fft_din` and `add_rd` are valid.
- `add_rd`  out  N  sample index that accompanies `fft_load`.
- `fft_din`  out  BIT_WIDTH  sample data sent to the FFT.
- `fft_start`  out  1  one-cycle pulse issued after the last load.
- `occupancy`  out  $clog2(NUM_BANKS+1)  number of full banks not yet released.
- `capturing`  out  1  write side is accepting samples.
- `overflow`  out  1  sticky flag: a sample was dropped.
- `drop_count`  out  DROP_W  saturating count of dropped samples.

## Operation

**Write side**
- State held: `wr_bank` (mod NUM_BANKS), `wr_idx` (N bits), and one `full` bit per bank.
- On `sample_valid` with `capturing` high and `full[wr_bank]` low: write `sample_in` to bank `wr_bank` at address `wr_idx`, then increment `wr_idx`.
- When `wr_idx == FRAME_SIZE-1` is written:
  - set `full[wr_bank]`;
  - set `wr_idx` to 0;
  - advance `wr_bank` to `(wr_bank+1) mod NUM_BANKS`;
  - if `continuous` is 0, clear `capturing`.
- On `sample_valid` while `full[wr_bank]` is high (the ring is full): do not write; set `overflow`; increment `drop_count`, saturating at all-ones.
- While `capturing` is low, samples are ignored. This is not counted as overflow.
- `arm` sets `capturing`. `capturing` is held at 1 whenever `continuous` is 1.

**Read side FSM** (oldest frame first; `rd_bank` mod NUM_BANKS)
- IDLE: if `full[rd_bank]`, clear `rd_idx` and go to LOAD.
- LOAD: drive bank address = `rd_idx` and increment `rd_idx` each cycle. After FRAME_SIZE addresses have been issued, go to DRAIN.
- DRAIN: one cycle that covers the final RAM read latency. Go to START.
- START: `fft_start` = 1 for this one cycle. Go to WAIT.
- WAIT: on `fft_done`, clear `full[rd_bank]`, advance `rd_bank`, and go to IDLE.
- `fft_done` in any state other than WAIT is ignored.

**Occupancy and simultaneous events**
- `occupancy` = popcount of `full`, kept as a counter.
- A frame completing on the write side and a release on the read side in the same cycle leaves `occupancy` unchanged. Both `full` bits update.
- A release and a sample arriving for the just-released bank in the same cycle: the sample is dropped, because `full` is evaluated before the update.
- `clr_ovf` together with a drop in the same cycle: the result is `overflow` = 1 and `drop_count` = 1.
- The write side never targets a bank with its `full` bit set, so it can never touch the bank being read.

**Reset**
- All state is cleared: IDLE, both pointers 0, `full` = 0, `capturing` = 1.
- Reset in mid-frame or mid-LOAD discards all data.

## Timing

- **Reset values:** `fft_load` = 0, `add_rd` = 0, `fft_din` = 0 (registered), `fft_start` = 0, `occupancy` = 0, `capturing` = 1, `overflow` = 0, `drop_count` = 0.
- **RAM:** read latency is 1 cycle. `fft_load` and `add_rd` are the LOAD-cycle strobe and `rd_idx`, each delayed one register stage. `fft_load` is high for exactly FRAME_SIZE consecutive cycles, with `add_rd` running 0..FRAME_SIZE-1.
- **Write-to-read latency:** the cycle after the final write sets `full`. IDLE sees it in the next cycle. The first `fft_load` follows 2 cycles after that.
- **`fft_start`:** asserted in the cycle immediately after the last `fft_load` cycle.
- **Back-to-back frames:** a queued frame begins LOAD one cycle after the `fft_done` release.

## Structure

- **Package `fft_buf_pkg`:**
  - read FSM enum `rdstate_t` {IDLE, LOAD, DRAIN, START, WAIT};
  - constant function `bank_next()` for the mod-NUM_BANKS increment.
- **Sub-module:** the existing `ram1p` (BIT_WIDTH, N), instantiated NUM_BANKS times in a generate loop.
- **Address mux:** each bank takes the read address when it is `rd_bank` and the read FSM is in LOAD; otherwise it takes `wr_idx`.
- **Data mux:** the output mux selects the bank data using the delayed `rd_bank`.

## Test plan

- **Single frame:** NUM_BANKS=2, N=4. Send 16 samples (value = index). Expect `fft_load` high for 16 cycles, `add_rd` 0..15, `fft_din` 0..15, and `fft_start` on the next cycle. `occupancy` is 1 until `fft_done`, then 0.
- **Overflow:** NUM_BANKS=3, N=4, `fft_done` held low. Send 56 samples. Expect `occupancy` = 3, `overflow` = 1, `drop_count` = 8. Then pulse `clr_ovf` and expect `drop_count` = 0.
- **Wrap-around:** NUM_BANKS=3. Stream 7 frames with tagged data, answering `fft_done` promptly. Expect the FFT to receive frames 0..6 in order with no drops.
- **Simultaneous complete and release:** time the last write of frame 2 to the `fft_done` cycle of frame 0. Expect `occupancy` to stay at 2 and both `full` bits to update.
- **Single-shot:** `continuous` = 0. Send 20 samples with N=4. Expect `capturing` to go low after 16, `drop_count` to stay 0, and 4 samples to be ignored. After `arm`, the next frame is captured.
- **Reset mid-LOAD:** assert `reset` at `add_rd` = 7. Expect all outputs at reset values immediately, and no `fft_start`.
